// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states,
// input polarity constants and a constant-width helper.
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_e;

   localparam bit POL_ACTIVE_HIGH = 1'b0;
   localparam bit POL_ACTIVE_LOW  = 1'b1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 32'd0;
      while ((64'd1 << width) < 64'(value)) begin
         width = width + 32'd1;
      end
      return width;
   endfunction

   function automatic int unsigned clog2_min1(input int unsigned value);
      return (clog2(value) < 32'd1) ? 32'd1 : clog2(value);
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned per-channel level/event outputs.
interface button_conditioner_if #(
   parameter int unsigned N = 1
);
   logic [N-1:0] switchin;
   logic [N-1:0] switchout;
   logic [N-1:0] press;
   logic [N-1:0] release_pulse;
   logic [N-1:0] long_press;
   logic [N-1:0] repeat_pulse;

   modport master (
      output switchin,
      input  switchout, press, release_pulse, long_press, repeat_pulse
   );

   modport slave (
      input  switchin,
      output switchout, press, release_pulse, long_press, repeat_pulse
   );
endinterface

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, symmetric debounce filter and
// press/held FSM producing single-cycle press, release, long and repeat events.
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 20,
   parameter int unsigned LONG_TICKS   = 2000,
   parameter int unsigned REPEAT_TICKS = 200,
   parameter bit          ACTIVE_LOW   = POL_ACTIVE_HIGH
) (
   input  logic clk,
   input  logic sysclr_n,
   input  logic sample,
   input  logic switchin,
   output logic switchout,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse
);

   localparam int unsigned SW = clog2(STABLE_TICKS + 32'd1);
   localparam int unsigned HW = clog2(LONG_TICKS + 32'd1);
   localparam int unsigned RW = clog2_min1(REPEAT_TICKS + 32'd1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 32'd1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 32'd1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 32'd1);
   localparam bit            REP_EN    = (REPEAT_TICKS != 32'd0);

   logic          sync1_r;
   logic          sync2_r;
   logic          switchout_r;
   logic [SW-1:0] stab_cnt_r;
   logic [HW-1:0] hold_cnt_r;
   logic [RW-1:0] rep_cnt_r;
   btn_state_e    state_r;
   logic          press_r;
   logic          release_r;
   logic          long_r;
   logic          repeat_r;

   logic          level_s;
   logic          differs_s;
   logic          toggle_s;
   logic          rise_s;
   logic          fall_s;
   logic [HW-1:0] hold_next_s;

   // Normalised level and the debounce decision for this clock.
   always_comb begin
      level_s     = sync2_r ^ ACTIVE_LOW;
      differs_s   = level_s ^ switchout_r;
      toggle_s    = sample & differs_s & (stab_cnt_r == STAB_LAST);
      rise_s      = toggle_s & ~switchout_r;
      fall_s      = toggle_s & switchout_r;
      hold_next_s = hold_cnt_r + HW'(1'b1);
   end

   // Two-flop synchroniser, reset to the released pad level.
   always_ff @(posedge clk or negedge sysclr_n) begin
      if (!sysclr_n) begin
         sync1_r <= ACTIVE_LOW;
         sync2_r <= ACTIVE_LOW;
      end else begin
         sync1_r <= switchin;
         sync2_r <= sync1_r;
      end
   end

   // Debounce filter: a run of differing samples flips the level, any agreeing sample restarts it.
   always_ff @(posedge clk or negedge sysclr_n) begin
      if (!sysclr_n) begin
         switchout_r <= 1'b0;
         stab_cnt_r  <= {SW{1'b0}};
      end else if (toggle_s) begin
         switchout_r <= ~switchout_r;
         stab_cnt_r  <= {SW{1'b0}};
      end else if (sample) begin
         if (differs_s) begin
            stab_cnt_r <= stab_cnt_r + SW'(1'b1);
         end else begin
            stab_cnt_r <= {SW{1'b0}};
         end
      end
   end

   // Press/held FSM; a falling level always takes priority over long/repeat.
   // long_press lands LONG_TICKS-1 samples after press, repeats every REPEAT_TICKS samples.
   always_ff @(posedge clk or negedge sysclr_n) begin
      if (!sysclr_n) begin
         state_r    <= ST_IDLE;
         hold_cnt_r <= {HW{1'b0}};
         rep_cnt_r  <= {RW{1'b0}};
         press_r    <= 1'b0;
         release_r  <= 1'b0;
         long_r     <= 1'b0;
         repeat_r   <= 1'b0;
      end else begin
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  press_r    <= 1'b1;
                  hold_cnt_r <= {HW{1'b0}};
                  rep_cnt_r  <= {RW{1'b0}};
                  state_r    <= ST_PRESSED;
               end
            end
            ST_PRESSED: begin
               if (fall_s) begin
                  release_r  <= 1'b1;
                  hold_cnt_r <= {HW{1'b0}};
                  rep_cnt_r  <= {RW{1'b0}};
                  state_r    <= ST_IDLE;
               end else if (sample) begin
                  hold_cnt_r <= hold_next_s;
                  if (hold_next_s == HOLD_LAST) begin
                     long_r    <= 1'b1;
                     rep_cnt_r <= {RW{1'b0}};
                     state_r   <= ST_HELD;
                  end
               end
            end
            ST_HELD: begin
               if (fall_s) begin
                  release_r  <= 1'b1;
                  hold_cnt_r <= {HW{1'b0}};
                  rep_cnt_r  <= {RW{1'b0}};
                  state_r    <= ST_IDLE;
               end else if (sample && REP_EN) begin
                  if (rep_cnt_r == REP_LAST) begin
                     repeat_r  <= 1'b1;
                     rep_cnt_r <= {RW{1'b0}};
                  end else begin
                     rep_cnt_r <= rep_cnt_r + RW'(1'b1);
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               hold_cnt_r <= {HW{1'b0}};
               rep_cnt_r  <= {RW{1'b0}};
            end
         endcase
      end
   end

   assign switchout     = switchout_r;
   assign press         = press_r;
   assign release_pulse = release_r;
   assign long_press    = long_r;
   assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: shared sample prescaler feeding
// independent debounce/event channels.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned N            = 1,
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned SAMPLE_HZ    = 2000,
   parameter int unsigned STABLE_TICKS = 20,
   parameter int unsigned LONG_TICKS   = 2000,
   parameter int unsigned REPEAT_TICKS = 200,
   parameter bit          ACTIVE_LOW   = POL_ACTIVE_HIGH
) (
   input logic                 clk,
   input logic                 sysclr_n,
   button_conditioner_if.slave bus
);

   localparam int unsigned DIV = CLK_FREQ_HZ / SAMPLE_HZ;
   localparam int unsigned PW  = clog2_min1(DIV);
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 32'd1);

   if (DIV < 32'd2) begin : g_bad_div
      $error("button_conditioner: CLK_FREQ_HZ/SAMPLE_HZ must be at least 2");
   end
   if (STABLE_TICKS < 32'd1) begin : g_bad_stable
      $error("button_conditioner: STABLE_TICKS must be at least 1");
   end
   if (LONG_TICKS <= STABLE_TICKS) begin : g_bad_long
      $error("button_conditioner: LONG_TICKS must exceed STABLE_TICKS");
   end

   logic [PW-1:0] count_r;
   logic          sample_s;
   logic [N-1:0]  switchout_s;
   logic [N-1:0]  press_s;
   logic [N-1:0]  release_s;
   logic [N-1:0]  long_s;
   logic [N-1:0]  repeat_s;

   // Free-running sample prescaler shared by all channels.
   always_ff @(posedge clk or negedge sysclr_n) begin
      if (!sysclr_n) begin
         count_r <= {PW{1'b0}};
      end else if (count_r == DIV_LAST) begin
         count_r <= {PW{1'b0}};
      end else begin
         count_r <= count_r + PW'(1'b1);
      end
   end

   assign sample_s = (count_r == DIV_LAST);

   for (genvar i = 0; i < N; i++) begin : g_ch
      button_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_channel (
         .clk           (clk),
         .sysclr_n      (sysclr_n),
         .sample        (sample_s),
         .switchin      (bus.switchin[i]),
         .switchout     (switchout_s[i]),
         .press         (press_s[i]),
         .release_pulse (release_s[i]),
         .long_press    (long_s[i]),
         .repeat_pulse  (repeat_s[i])
      );
   end

   assign bus.switchout     = switchout_s;
   assign bus.press         = press_s;
   assign bus.release_pulse = release_s;
   assign bus.long_press    = long_s;
   assign bus.repeat_pulse  = repeat_s;

endmodule
